// File: rtl/dcache_control.sv
// Set-associative data cache controller: hit check, dirty-victim writeback,
// line allocate, and LRU/array write-enable sequencing.
module dcache_control #(
  parameter  int LOG2_WAYS  = 3,
  parameter  int INDEX_BITS = 8,
  localparam int NUM_WAYS   = 2**LOG2_WAYS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [INDEX_BITS-1:0] index,
  input  logic [NUM_WAYS-1:0]   way_hit,
  input  logic [LOG2_WAYS-1:0]  lru_way,
  input  logic                  victim_dirty,
  input  logic                  pmem_resp,
  output logic                  mem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic                  array_load,
  output logic [INDEX_BITS-1:0] write_to_index,
  output logic [NUM_WAYS-1:0]   tag_load,
  output logic [NUM_WAYS-1:0]   data_load,
  output logic [NUM_WAYS-1:0]   valid_load,
  output logic [NUM_WAYS-1:0]   dirty_load,
  output logic                  lru_load,
  output logic [LOG2_WAYS-1:0]  lru_wdata,
  output logic                  valid_wdata,
  output logic                  dirty_wdata,
  output logic                  fill_sel
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WRITEBACK,
    ALLOCATE
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [INDEX_BITS-1:0]   r_index;
  logic [LOG2_WAYS-1:0]    r_victim;
  logic                    w_req;
  logic                    w_hit;
  logic [LOG2_WAYS-1:0]    w_hit_idx;
  logic [NUM_WAYS-1:0]     w_hit_oh;
  logic [NUM_WAYS-1:0]     w_vic_oh;

  assign w_req    = mem_read | mem_write;
  assign w_hit    = |way_hit;
  assign w_hit_oh = NUM_WAYS'(1) << w_hit_idx;
  assign w_vic_oh = NUM_WAYS'(1) << r_victim;
  assign write_to_index = rst ? '0 : r_index;

  // Descending scan so the lowest set bit wins on multi-hit.
  always_comb begin
    w_hit_idx = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (way_hit[i]) w_hit_idx = LOG2_WAYS'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_index  <= '0;
      r_victim <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_req) r_index <= index;
      if (r_state == CHECK && !w_hit) r_victim <= lru_way;
    end
  end

  always_comb begin
    w_next      = r_state;
    mem_resp    = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    array_load  = 1'b0;
    tag_load    = '0;
    data_load   = '0;
    valid_load  = '0;
    dirty_load  = '0;
    lru_load    = 1'b0;
    lru_wdata   = '0;
    valid_wdata = 1'b0;
    dirty_wdata = 1'b0;
    fill_sel    = 1'b0;
    // Outputs are forced low for the whole reset cycle, aborting transfers.
    if (!rst) begin
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            array_load = 1'b1;
            w_next     = CHECK;
          end
        end
        CHECK: begin
          if (w_hit) begin
            mem_resp  = 1'b1;
            lru_load  = 1'b1;
            lru_wdata = w_hit_idx + LOG2_WAYS'(1);
            if (mem_write) begin
              data_load   = w_hit_oh;
              dirty_load  = w_hit_oh;
              dirty_wdata = 1'b1;
            end
            w_next = IDLE;
          end else begin
            w_next = victim_dirty ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          pmem_write = 1'b1;
          if (pmem_resp) w_next = ALLOCATE;
        end
        ALLOCATE: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            tag_load    = w_vic_oh;
            data_load   = w_vic_oh;
            valid_load  = w_vic_oh;
            dirty_load  = w_vic_oh;
            valid_wdata = 1'b1;
            fill_sel    = 1'b1;
            array_load  = 1'b1;
            w_next      = CHECK;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_control.sv
// Directed bench for dcache_control: hits, clean/dirty miss, reset abort.
module tb_dcache_control;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_read, mem_write;
  logic [7:0] index;
  logic [7:0] way_hit;
  logic [2:0] lru_way;
  logic       victim_dirty, pmem_resp;
  logic       mem_resp, pmem_read, pmem_write, array_load;
  logic [7:0] write_to_index;
  logic [7:0] tag_load, data_load, valid_load, dirty_load;
  logic       lru_load;
  logic [2:0] lru_wdata;
  logic       valid_wdata, dirty_wdata, fill_sel;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dcache_control dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .index(index), .way_hit(way_hit),
    .lru_way(lru_way), .victim_dirty(victim_dirty),
    .pmem_resp(pmem_resp), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .array_load(array_load), .write_to_index(write_to_index),
    .tag_load(tag_load), .data_load(data_load),
    .valid_load(valid_load), .dirty_load(dirty_load),
    .lru_load(lru_load), .lru_wdata(lru_wdata),
    .valid_wdata(valid_wdata), .dirty_wdata(dirty_wdata),
    .fill_sel(fill_sel)
  );

  logic [54:0] w_all;
  assign w_all = {mem_resp, pmem_read, pmem_write, array_load,
                  write_to_index, tag_load, data_load, valid_load,
                  dirty_load, lru_load, lru_wdata, valid_wdata,
                  dirty_wdata, fill_sel};

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_read = 0; mem_write = 0; index = 0;
    way_hit = 0; lru_way = 0; victim_dirty = 0; pmem_resp = 0;
    mem_read = 1'b1;
    tick(); tick();
    #1;
    chk("rst_outputs_zero", 64'(w_all), 0);

    // Read hit on way 2
    rst = 0; mem_read = 1; index = 8'h5A;
    #1;
    chk("rd_accept_array_load", 64'(array_load), 1);
    chk("rd_accept_no_resp", 64'(mem_resp), 0);
    tick();
    index = 8'h11; way_hit = 8'b0000_0100;
    #1;
    chk("rd_index_reg", 64'(write_to_index), 8'h5A);
    chk("rd_hit_resp", 64'(mem_resp), 1);
    chk("rd_hit_lru_load", 64'(lru_load), 1);
    chk("rd_hit_lru_wdata", 64'(lru_wdata), 3);
    chk("rd_hit_no_data_load", 64'(data_load), 0);
    chk("rd_hit_no_dirty_load", 64'(dirty_load), 0);
    tick();
    mem_read = 0; way_hit = 0;
    #1;
    chk("rd_resp_single_pulse", 64'(mem_resp), 0);
    chk("idle_no_loads", 64'({data_load, tag_load, lru_load}), 0);

    // Write hit, multi-hit with both read and write asserted
    mem_read = 1; mem_write = 1; index = 8'h33;
    #1;
    chk("wr_accept", 64'(array_load), 1);
    tick();
    index = 8'h44; way_hit = 8'b0001_0010;
    #1;
    chk("wr_data_load", 64'(data_load), 8'b0000_0010);
    chk("wr_dirty_load", 64'(dirty_load), 8'b0000_0010);
    chk("wr_dirty_wdata", 64'(dirty_wdata), 1);
    chk("wr_fill_sel", 64'(fill_sel), 0);
    chk("wr_resp", 64'(mem_resp), 1);
    chk("wr_lru_wdata", 64'(lru_wdata), 2);
    chk("wr_index_held", 64'(write_to_index), 8'h33);
    tick();
    // Back-to-back read accepted in the IDLE cycle
    mem_write = 0; way_hit = 0;
    #1;
    chk("b2b_accept", 64'(array_load), 1);
    tick();
    way_hit = 8'b0000_0001;
    #1;
    chk("b2b_index", 64'(write_to_index), 8'h44);
    chk("b2b_resp", 64'(mem_resp), 1);
    chk("b2b_lru_wdata", 64'(lru_wdata), 1);
    chk("b2b_no_data_load", 64'(data_load), 0);
    tick();
    mem_read = 0; way_hit = 0;

    // Clean miss, victim 5, pmem_resp on 4th ALLOCATE cycle
    mem_read = 1; index = 8'h10;
    tick();
    lru_way = 3'd5; victim_dirty = 0;
    #1;
    chk("cm_check_no_resp", 64'(mem_resp), 0);
    chk("cm_check_no_pmem", 64'({pmem_read, pmem_write}), 0);
    tick();
    lru_way = 3'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("cm_alloc_wait", 64'({pmem_read, pmem_write, tag_load}),
          {1'b1, 1'b0, 8'h00});
      tick();
    end
    pmem_resp = 1;
    #1;
    chk("cm_pmem_read_4", 64'(pmem_read), 1);
    chk("cm_tag_load", 64'(tag_load), 8'b0010_0000);
    chk("cm_data_load", 64'(data_load), 8'b0010_0000);
    chk("cm_valid_load", 64'(valid_load), 8'b0010_0000);
    chk("cm_dirty_load", 64'(dirty_load), 8'b0010_0000);
    chk("cm_wdata", 64'({valid_wdata, dirty_wdata, fill_sel}), 3'b101);
    chk("cm_array_load", 64'(array_load), 1);
    tick();
    pmem_resp = 0; way_hit = 8'b0010_0000;
    #1;
    chk("cm_retry_resp", 64'(mem_resp), 1);
    chk("cm_retry_lru", 64'(lru_wdata), 6);
    tick();
    mem_read = 0; way_hit = 0;

    // Dirty miss, victim 7, write request
    mem_write = 1; index = 8'hC3;
    tick();
    lru_way = 3'd7; victim_dirty = 1;
    tick();
    victim_dirty = 0; lru_way = 3'd1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("dm_wb_wait", 64'({pmem_write, pmem_read}), 2'b10);
      tick();
    end
    pmem_resp = 1;
    #1;
    chk("dm_wb_resp", 64'({pmem_write, pmem_read, tag_load}),
        {2'b10, 8'h00});
    tick();
    pmem_resp = 0;
    #1;
    chk("dm_alloc_wait", 64'({pmem_write, pmem_read}), 2'b01);
    tick();
    pmem_resp = 1;
    #1;
    chk("dm_tag_load", 64'(tag_load), 8'b1000_0000);
    chk("dm_fill", 64'({fill_sel, dirty_wdata}), 2'b10);
    tick();
    pmem_resp = 0; way_hit = 8'b1000_0000;
    #1;
    chk("dm_wr_data_load", 64'(data_load), 8'b1000_0000);
    chk("dm_dirty", 64'({dirty_load, dirty_wdata}), {8'h80, 1'b1});
    chk("dm_lru_wrap", 64'(lru_wdata), 0);
    chk("dm_resp", 64'(mem_resp), 1);
    chk("dm_index", 64'(write_to_index), 8'hC3);
    tick();
    mem_write = 0; way_hit = 0;

    // Reset during ALLOCATE
    mem_read = 1; index = 8'h77;
    tick();
    lru_way = 3'd3;
    tick();
    #1;
    chk("ra_in_alloc", 64'(pmem_read), 1);
    rst = 1; pmem_resp = 1;
    #1;
    chk("ra_rst_outputs_zero", 64'(w_all), 0);
    tick();
    rst = 0; mem_read = 0;
    #1;
    chk("ra_idle_stray_resp", 64'(w_all), 0);
    tick();
    pmem_resp = 0;
    #1;
    chk("ra_still_idle", 64'(w_all), 0);
    mem_read = 1;
    #1;
    chk("ra_accept_after", 64'(array_load), 1);
    tick();
    mem_read = 0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/dcache_control.md
DCACHE_CONTROL -- requirements
Module: dcache_control

Interface
REQ-001 The module SHALL take parameter LOG2_WAYS, default 3, as log2 of the associativity, with NUM_WAYS = 2**LOG2_WAYS.
REQ-002 The module SHALL take parameter INDEX_BITS, default 8, as the set index width.
REQ-003 The module SHALL have these ports:
- clk  in  1  clock; one clock domain, all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_read  in  1  CPU read request, held until mem_resp.
- mem_write  in  1  CPU write request, held until mem_resp.
- index  in  INDEX_BITS  set index decoded from the CPU address.
- way_hit  in  NUM_WAYS  per-way (valid AND tag match), meaningful in CHECK only.
- lru_way  in  LOG2_WAYS  victim way read from the LRU array.
- victim_dirty  in  1  dirty bit of way lru_way.
- pmem_resp  in  1  physical-memory line-transfer done.
- mem_resp  out  1  CPU request complete.
- pmem_read  out  1  line-fill request.
- pmem_write  out  1  line-writeback request.
- array_load  out  1  BRAM read enable.
- write_to_index  out  INDEX_BITS  registered set index for all array writes.
- tag_load, data_load, valid_load, dirty_load  out  NUM_WAYS each  per-way write enables.
- lru_load  out  1  LRU write enable.
- lru_wdata  out  LOG2_WAYS  next victim way.
- valid_wdata, dirty_wdata  out  1 each  bit write data.
- fill_sel  out  1  data source select: 0 = CPU byte merge, 1 = pmem line.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, CHECK, WRITEBACK, ALLOCATE.
REQ-005 In IDLE, when mem_read or mem_write is 1, the module SHALL assert array_load, register index into write_to_index, and go to CHECK.
REQ-006 When mem_read and mem_write are both 1, the request SHALL be treated as a write.
REQ-007 In CHECK with a nonzero way_hit, hit way h SHALL be the lowest set bit of way_hit.
REQ-008 On a read hit, the module SHALL assert mem_resp and lru_load with lru_wdata = (h+1) mod NUM_WAYS for one cycle, then go to IDLE.
REQ-009 On a write hit, the module SHALL additionally assert data_load[h] and dirty_load[h] with dirty_wdata = 1 and fill_sel = 0, in the same cycle as mem_resp.
REQ-010 On a miss (way_hit = 0), the module SHALL latch lru_way as victim v, then go to WRITEBACK if victim_dirty = 1, otherwise to ALLOCATE.
REQ-011 In WRITEBACK, the module SHALL hold pmem_write = 1 until pmem_resp, then go to ALLOCATE.
REQ-012 In ALLOCATE, the module SHALL hold pmem_read = 1 until pmem_resp.
REQ-013 On that pmem_resp, the module SHALL pulse tag_load[v], data_load[v], valid_load[v] (valid_wdata = 1) and dirty_load[v] (dirty_wdata = 0) with fill_sel = 1, assert array_load, and go to CHECK; the retried CHECK SHALL then hit.
REQ-014 A read hit SHALL complete in 2 cycles (mem_resp in the cycle after acceptance), and mem_resp SHALL be a single-cycle pulse.
REQ-015 pmem_resp received outside WRITEBACK and ALLOCATE SHALL be ignored.
REQ-016 write_to_index SHALL change only on acceptance in IDLE.
REQ-017 All per-way enables SHALL be one-hot or zero in every cycle.
REQ-018 No write enable SHALL be asserted in IDLE.
REQ-019 A request in IDLE SHALL be accepted in the same cycle that a previous mem_resp completes into IDLE, i.e. with no bubble beyond IDLE.

Reset
REQ-020 While rst = 1, the module SHALL enter IDLE, clear write_to_index and v to 0, and drive every output to 0.
REQ-021 Reset asserted mid-WRITEBACK or mid-ALLOCATE SHALL abort the transfer with no array write.

Verification
REQ-022 Read hit, way 2 (NUM_WAYS = 8): mem_read, way_hit = 8'b00000100 -> mem_resp in cycle 2, lru_load = 1, lru_wdata = 3, no data_load.
REQ-023 Write hit, multi-hit: way_hit = 8'b00010010 -> data_load = 8'b00000010, dirty_load = 8'b00000010, dirty_wdata = 1, mem_resp on that cycle.
REQ-024 Clean miss: way_hit = 0, lru_way = 5, victim_dirty = 0, pmem_resp after 4 cycles -> pmem_read held for 4 cycles, then tag/data/valid/dirty_load = 8'b00100000, fill_sel = 1, retried CHECK hit, then mem_resp.
REQ-025 Dirty miss: victim_dirty = 1 -> pmem_write until pmem_resp, then pmem_read, and never both asserted in the same cycle.
REQ-026 rst pulsed during ALLOCATE -> next cycle IDLE, all outputs 0, no load asserted; a stray pmem_resp afterwards is ignored.
